// File: rtl/uart_msg_gen_pkg.sv
// Shared types and constants for the UART message composer.
// UART_MSG_GEN_CHECKSUM_EN adds the XOR checksum state and sets CK=1.
package uart_msg_pkg;

  typedef enum logic [1:0] {
    MODE_PATTERN = 2'd0,
    MODE_FILL    = 2'd1,
    MODE_ECHO    = 2'd2,
    MODE_ECHO_UC = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_PAY   = 3'd2,
`ifdef UART_MSG_GEN_CHECKSUM_EN
    S_CK    = 3'd3,
`endif
    S_CR    = 3'd4,
    S_LF    = 3'd5,
    S_DONE  = 3'd6
  } state_e;

`ifdef UART_MSG_GEN_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  localparam logic [7:0] CHR_CR   = 8'h0D;
  localparam logic [7:0] CHR_LF   = 8'h0A;
  localparam logic [7:0] CHR_LC_A = 8'h61;
  localparam logic [7:0] CHR_LC_Z = 8'h7A;
  localparam logic [7:0] CHR_CASE = 8'h20;

endpackage

// File: rtl/uart_msg_gen_if.sv
// Command, source-RAM, TX-RAM and message-handoff signals of the composer.
interface uart_msg_gen_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [AW-1:0]    cmd_len;
  logic [WIDTH-1:0] cmd_arg;
  logic [AW-1:0]    src_addr;
  logic [WIDTH-1:0] src_dout;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] din;
  logic             we;
  logic             msg_valid;
  logic             msg_ready;
  logic [AW:0]      msg_len;

  modport master (
    input  cmd_valid, cmd_mode, cmd_len, cmd_arg, src_dout, msg_ready,
    output cmd_ready, src_addr, addr, din, we, msg_valid, msg_len
  );

  modport slave (
    output cmd_valid, cmd_mode, cmd_len, cmd_arg, src_dout, msg_ready,
    input  cmd_ready, src_addr, addr, din, we, msg_valid, msg_len
  );
endinterface

// File: rtl/uart_msg_gen_xform.sv
// Combinational per-mode payload character: pattern ramp, fill, echo, echo upper-cased.
module uart_msg_xform
  import uart_msg_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int AW       = 8,
  parameter int BASE_CHR = 64
) (
  input  mode_e            mode_i,
  input  logic [AW-1:0]    idx_i,
  input  logic [WIDTH-1:0] arg_i,
  input  logic [WIDTH-1:0] src_i,
  output logic [WIDTH-1:0] chr_o
);
  logic [WIDTH-1:0] base;
  logic             is_lc;

  // A zero argument selects the default ramp start
  assign base  = (arg_i == '0) ? WIDTH'(BASE_CHR) : arg_i;
  assign is_lc = (src_i >= WIDTH'(CHR_LC_A)) && (src_i <= WIDTH'(CHR_LC_Z));

  always_comb begin
    chr_o = '0;
    case (mode_i)
      MODE_PATTERN: chr_o = base + WIDTH'(idx_i);
      MODE_FILL:    chr_o = arg_i;
      MODE_ECHO:    chr_o = src_i;
      MODE_ECHO_UC: chr_o = is_lc ? (src_i - WIDTH'(CHR_CASE)) : src_i;
      default:      chr_o = '0;
    endcase
  end
endmodule

// File: rtl/uart_msg_gen.sv
// Message composer: payload, optional checksum (UART_MSG_GEN_CHECKSUM_EN), CR LF,
// then holds msg_valid/msg_len until the TX sequencer takes the message.
module uart_msg_gen
  import uart_msg_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LEN      = 256,
  parameter int BASE_CHR = 64
) (
  input  logic           clk,
  input  logic           rst,
  uart_msg_gen_if.master bus
);
  localparam int AW   = $clog2(LEN);
  localparam int MAXN = LEN - 2 - CK;

`ifdef UART_MSG_GEN_CHECKSUM_EN
  localparam state_e AFTER_PAY = S_CK;
`else
  localparam state_e AFTER_PAY = S_CR;
`endif

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [AW-1:0]    n_q, n_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] arg_q, arg_d;
  logic [WIDTH-1:0] pay_chr;
  logic [AW-1:0]    n_clamp;
  logic             cmd_echo;
`ifdef UART_MSG_GEN_CHECKSUM_EN
  logic [WIDTH-1:0] ck_q, ck_d;
`endif

  assign n_clamp  = (bus.cmd_len > AW'(MAXN)) ? AW'(MAXN) : bus.cmd_len;
  assign cmd_echo = bus.cmd_mode[1];

  uart_msg_xform #(
    .WIDTH    (WIDTH),
    .AW       (AW),
    .BASE_CHR (BASE_CHR)
  ) u_xform (
    .mode_i (mode_q),
    .idx_i  (idx_q),
    .arg_i  (arg_q),
    .src_i  (bus.src_dout),
    .chr_o  (pay_chr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_PATTERN;
      n_q     <= '0;
      idx_q   <= '0;
      arg_q   <= '0;
`ifdef UART_MSG_GEN_CHECKSUM_EN
      ck_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      arg_q   <= arg_d;
`ifdef UART_MSG_GEN_CHECKSUM_EN
      ck_q    <= ck_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    n_d           = n_q;
    idx_d         = idx_q;
    arg_d         = arg_q;
`ifdef UART_MSG_GEN_CHECKSUM_EN
    ck_d          = ck_q;
`endif
    bus.cmd_ready = 1'b0;
    bus.src_addr  = '0;
    bus.addr      = '0;
    bus.din       = '0;
    bus.we        = 1'b0;
    bus.msg_valid = 1'b0;
    bus.msg_len   = '0;

    case (state_q)
      S_IDLE: begin
        bus.cmd_ready = ~rst;
        if (bus.cmd_valid && !rst) begin
          mode_d = mode_e'(bus.cmd_mode);
          n_d    = n_clamp;
          arg_d  = bus.cmd_arg;
          idx_d  = '0;
`ifdef UART_MSG_GEN_CHECKSUM_EN
          ck_d   = '0;
`endif
          if (cmd_echo)            state_d = S_PRIME;
          else if (n_clamp == '0)  state_d = AFTER_PAY;
          else                     state_d = S_PAY;
        end
      end
      // Read of byte 0 goes out here so src_dout is valid on the first payload cycle
      S_PRIME: begin
        bus.src_addr = '0;
        state_d      = (n_q == '0) ? AFTER_PAY : S_PAY;
      end
      S_PAY: begin
        bus.we       = 1'b1;
        bus.addr     = idx_q;
        bus.din      = pay_chr;
        bus.src_addr = idx_q + AW'(1);
        idx_d        = idx_q + AW'(1);
`ifdef UART_MSG_GEN_CHECKSUM_EN
        ck_d         = ck_q ^ pay_chr;
`endif
        if (idx_q == n_q - AW'(1)) state_d = AFTER_PAY;
      end
`ifdef UART_MSG_GEN_CHECKSUM_EN
      S_CK: begin
        bus.we   = 1'b1;
        bus.addr = n_q;
        bus.din  = ck_q;
        state_d  = S_CR;
      end
`endif
      S_CR: begin
        bus.we   = 1'b1;
        bus.addr = n_q + AW'(CK);
        bus.din  = WIDTH'(CHR_CR);
        state_d  = S_LF;
      end
      S_LF: begin
        bus.we   = 1'b1;
        bus.addr = n_q + AW'(CK + 1);
        bus.din  = WIDTH'(CHR_LF);
        state_d  = S_DONE;
      end
      S_DONE: begin
        bus.msg_valid = 1'b1;
        bus.msg_len   = (AW+1)'(n_q) + (AW+1)'(CK + 2);
        if (bus.msg_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule
